// File: rtl/uart_packet_parser.sv
`default_nettype none
// ============================================================================
// Module   : uart_packet_parser
// Brief    : SYNC/CMD/LEN/payload/CHK framer downstream of the UART receiver.
//            Optional inter-byte timeout: define UART_PARSER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_packet_parser #(
    parameter int         MAX_PAYLOAD  = 8,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 100000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_RX_DV,
    input  logic [7:0]                         i_RX_Byte,
    output logic                               o_Pkt_Valid,
    output logic [7:0]                         o_Pkt_Cmd,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   o_Pkt_Len,
    output logic [8*MAX_PAYLOAD-1:0]           o_Pkt_Data,
    output logic                               o_Err_Checksum,
    output logic                               o_Err_Length,
    output logic                               o_Err_Timeout
);

    localparam int             c_LW      = $clog2(MAX_PAYLOAD + 1);
    localparam logic [7:0]     c_MAX_LEN = 8'(MAX_PAYLOAD);
    localparam logic [c_LW-1:0] c_ONE    = c_LW'(1);

    if (MAX_PAYLOAD < 1 || MAX_PAYLOAD > 16 || TIMEOUT_CLKS < 2) begin : g_param_check
        $error("uart_packet_parser: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_GET_CMD     = 3'd1,
        ST_GET_LEN     = 3'd2,
        ST_GET_PAYLOAD = 3'd3,
        ST_GET_CHK     = 3'd4
    } state_t;

    state_t                    r_state;
    logic [7:0]                r_cmd;
    logic [c_LW-1:0]           r_len;
    logic [7:0]                r_sum;
    logic [c_LW-1:0]           r_idx;
    logic [8*MAX_PAYLOAD-1:0]  r_buf;
    logic [7:0]                r_out_cmd;
    logic [c_LW-1:0]           r_out_len;
    logic [8*MAX_PAYLOAD-1:0]  r_out_data;
    logic                      r_valid;
    logic                      r_err_cs;
    logic                      r_err_len;
    logic                      r_err_to;
    logic                      w_timeout;
    logic [c_LW-1:0]           w_idx_next;

    assign w_idx_next = r_idx + c_ONE;

`ifdef UART_PARSER_TIMEOUT_EN
    localparam int              c_TW      = $clog2(TIMEOUT_CLKS);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CLKS - 2);

    logic [c_TW-1:0] r_to_cnt;

    // Fires on the edge that would take the count to TIMEOUT_CLKS-1; a DV on that edge wins.
    assign w_timeout = !i_RX_DV && (r_state != ST_IDLE) && (r_to_cnt == c_TO_LAST);

    always_ff @(posedge clk) begin
        if (rst || i_RX_DV || (r_state == ST_IDLE) || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_TW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_len      <= '0;
            r_sum      <= '0;
            r_idx      <= '0;
            r_buf      <= '0;
            r_out_cmd  <= '0;
            r_out_len  <= '0;
            r_out_data <= '0;
            r_valid    <= 1'b0;
            r_err_cs   <= 1'b0;
            r_err_len  <= 1'b0;
            r_err_to   <= 1'b0;
        end else begin
            r_valid   <= 1'b0;
            r_err_cs  <= 1'b0;
            r_err_len <= 1'b0;
            r_err_to  <= 1'b0;
            if (w_timeout) begin
                r_state  <= ST_IDLE;
                r_err_to <= 1'b1;
            end else if (i_RX_DV) begin
                case (r_state)
                    ST_IDLE: begin
                        if (i_RX_Byte == SYNC_BYTE) begin
                            r_state <= ST_GET_CMD;
                            r_sum   <= '0;
                        end
                    end
                    ST_GET_CMD: begin
                        r_cmd   <= i_RX_Byte;
                        r_sum   <= i_RX_Byte;
                        r_state <= ST_GET_LEN;
                    end
                    ST_GET_LEN: begin
                        if (i_RX_Byte > c_MAX_LEN) begin
                            r_err_len <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            // Buffer is cleared for zero-length frames too so unused bytes read as zero.
                            r_len   <= i_RX_Byte[c_LW-1:0];
                            r_sum   <= r_sum + i_RX_Byte;
                            r_idx   <= '0;
                            r_buf   <= '0;
                            r_state <= (i_RX_Byte == 8'd0) ? ST_GET_CHK : ST_GET_PAYLOAD;
                        end
                    end
                    ST_GET_PAYLOAD: begin
                        for (int i = 0; i < MAX_PAYLOAD; i++) begin
                            if (r_idx == c_LW'(i)) begin
                                r_buf[8*i +: 8] <= i_RX_Byte;
                            end
                        end
                        r_sum <= r_sum + i_RX_Byte;
                        r_idx <= w_idx_next;
                        if (w_idx_next == r_len) begin
                            r_state <= ST_GET_CHK;
                        end
                    end
                    ST_GET_CHK: begin
                        if (i_RX_Byte == r_sum) begin
                            r_out_cmd  <= r_cmd;
                            r_out_len  <= r_len;
                            r_out_data <= r_buf;
                            r_valid    <= 1'b1;
                        end else begin
                            r_err_cs <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_Pkt_Valid    = r_valid;
    assign o_Pkt_Cmd      = r_out_cmd;
    assign o_Pkt_Len      = r_out_len;
    assign o_Pkt_Data     = r_out_data;
    assign o_Err_Checksum = r_err_cs;
    assign o_Err_Length   = r_err_len;
    assign o_Err_Timeout  = r_err_to;

endmodule
`default_nettype wire
